// File: rtl/ysyx_220053_pkg.sv
// ysyx_220053_pkg: shared encodings for the load/store unit.
//   - MEM_OP_*  : funct3 memory-op encodings (size in [1:0], unsigned in [2])
//   - ST_*      : LSU FSM state encodings
//   - is_misaligned(): natural-alignment check on the low address bits
package ysyx_220053_pkg;

   localparam logic [2:0] MEM_OP_B  = 3'b000;
   localparam logic [2:0] MEM_OP_H  = 3'b001;
   localparam logic [2:0] MEM_OP_W  = 3'b010;
   localparam logic [2:0] MEM_OP_D  = 3'b011;
   localparam logic [2:0] MEM_OP_BU = 3'b100;
   localparam logic [2:0] MEM_OP_HU = 3'b101;
   localparam logic [2:0] MEM_OP_WU = 3'b110;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DREQ = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Access size comes from op[1:0]; bytes are always aligned.
   function automatic logic is_misaligned(input logic [2:0] op, input logic [2:0] addr_lo);
      logic mis;
      case (op[1:0])
         2'b00:   mis = 1'b0;
         2'b01:   mis = addr_lo[0];
         2'b10:   mis = |addr_lo[1:0];
         default: mis = |addr_lo;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/ysyx_220053_lsu_align.sv
// ysyx_220053_lsu_align: purely combinational data alignment for the LSU.
//   mem_op_i    : funct3 of the access
//   off_i       : byte lane offset within the cache line
//   line_i      : cache line read data
//   wdata_i     : store data (XLEN)
//   load_data_o : extracted, sign/zero-extended load value
//   wdata_o     : store data shifted into its lane of the line
//   wstrb_o     : byte strobes for the store (size bytes at the lane offset)
module ysyx_220053_lsu_align
   import ysyx_220053_pkg::*;
#(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned LINE_W = 128,
   localparam int unsigned OFF_W  = $clog2(LINE_W / 8),
   localparam int unsigned STRB_W = LINE_W / 8
) (
   input  logic [2:0]        mem_op_i,
   input  logic [OFF_W-1:0]  off_i,
   input  logic [LINE_W-1:0] line_i,
   input  logic [XLEN-1:0]   wdata_i,
   output logic [XLEN-1:0]   load_data_o,
   output logic [LINE_W-1:0] wdata_o,
   output logic [STRB_W-1:0] wstrb_o
);

   logic [LINE_W-1:0] line_shr;
   logic [XLEN-1:0]   raw;
   logic [STRB_W-1:0] size_mask;

   // Load extraction: bring the addressed lane down to bit 0, then extend.
   always_comb begin
      line_shr = line_i >> {off_i, 3'b000};
      raw      = line_shr[XLEN-1:0];
      case (mem_op_i)
         MEM_OP_B:  load_data_o = XLEN'($signed(raw[7:0]));
         MEM_OP_H:  load_data_o = XLEN'($signed(raw[15:0]));
         MEM_OP_W:  load_data_o = XLEN'($signed(raw[31:0]));
         MEM_OP_BU: load_data_o = XLEN'(raw[7:0]);
         MEM_OP_HU: load_data_o = XLEN'(raw[15:0]);
         MEM_OP_WU: load_data_o = XLEN'(raw[31:0]);
         default:   load_data_o = raw;
      endcase
   end

   // Store lane and strobe generation.
   always_comb begin
      case (mem_op_i[1:0])
         2'b00:   size_mask = STRB_W'(8'h01);
         2'b01:   size_mask = STRB_W'(8'h03);
         2'b10:   size_mask = STRB_W'(8'h0F);
         default: size_mask = STRB_W'(8'hFF);
      endcase
      wstrb_o = size_mask << off_i;
      wdata_o = LINE_W'(wdata_i) << {off_i, 3'b000};
   end

endmodule

// File: rtl/ysyx_220053_lsu.sv
// ysyx_220053_lsu: load/store unit between the pipeline and the data cache.
//   req_valid_i/req_ready_o   : request handshake (ready only when idle)
//   mem_op_i, mem_to_reg_i, mem_wen_i, csr_to_reg_i, addr_i, wdata_i, csrres_i : request
//   resp_valid_o/resp_ready_i : writeback handshake; rfdata_o, misalign_o qualify it
//   m_busy                    : FSM not idle
//   d_rw_*                    : cache request (valid/ready handshake, req=1 is write)
//   d_data_read_i             : cache line read data
module ysyx_220053_lsu
   import ysyx_220053_pkg::*;
#(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned LINE_W = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [2:0]          mem_op_i,
   input  logic                mem_to_reg_i,
   input  logic                mem_wen_i,
   input  logic                csr_to_reg_i,
   input  logic [XLEN-1:0]     addr_i,
   input  logic [XLEN-1:0]     wdata_i,
   input  logic [XLEN-1:0]     csrres_i,
   output logic                resp_valid_o,
   input  logic                resp_ready_i,
   output logic [XLEN-1:0]     rfdata_o,
   output logic                misalign_o,
   output logic                m_busy,
   output logic [XLEN-1:0]     d_rw_addr_o,
   output logic                d_rw_req_o,
   output logic                d_rw_valid_o,
   output logic [LINE_W-1:0]   d_rw_w_data_o,
   output logic [LINE_W/8-1:0] d_rw_wstrb_o,
   input  logic [LINE_W-1:0]   d_data_read_i,
   input  logic                d_rw_ready_i
);

   localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
   localparam int unsigned STRB_W = LINE_W / 8;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] csrres_q, csrres_d;
   logic [XLEN-1:0] rfdata_q, rfdata_d;
   logic [2:0]      mem_op_q, mem_op_d;
   logic            to_reg_q, to_reg_d;
   logic            wen_q, wen_d;
   logic            csr_q, csr_d;
   logic            misalign_q, misalign_d;

   logic              is_mem;
   logic              is_mis;
   logic [XLEN-1:0]   load_data;
   logic [LINE_W-1:0] st_wdata;
   logic [STRB_W-1:0] st_wstrb;

   ysyx_220053_lsu_align #(
      .XLEN   (XLEN),
      .LINE_W (LINE_W)
   ) u_align (
      .mem_op_i    (mem_op_q),
      .off_i       (addr_q[OFF_W-1:0]),
      .line_i      (d_data_read_i),
      .wdata_i     (wdata_q),
      .load_data_o (load_data),
      .wdata_o     (st_wdata),
      .wstrb_o     (st_wstrb)
   );

   // Next-state, request latching and writeback value selection.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      csrres_d   = csrres_q;
      rfdata_d   = rfdata_q;
      mem_op_d   = mem_op_q;
      to_reg_d   = to_reg_q;
      wen_d      = wen_q;
      csr_d      = csr_q;
      misalign_d = misalign_q;
      is_mem     = mem_to_reg_i | mem_wen_i;
      is_mis     = is_mem & is_misaligned(mem_op_i, addr_i[2:0]);

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               addr_d     = addr_i;
               wdata_d    = wdata_i;
               csrres_d   = csrres_i;
               mem_op_d   = mem_op_i;
               to_reg_d   = mem_to_reg_i;
               wen_d      = mem_wen_i;
               csr_d      = csr_to_reg_i;
               misalign_d = is_mis;
               if (is_mem && !is_mis) begin
                  state_d = ST_DREQ;
               end else begin
                  // No cache access: the writeback value is known now.
                  state_d = ST_RESP;
                  if (is_mis)            rfdata_d = '0;
                  else if (csr_to_reg_i) rfdata_d = csrres_i;
                  else                   rfdata_d = addr_i;
               end
            end
         end
         ST_DREQ: begin
            if (d_rw_ready_i) begin
               state_d = ST_RESP;
               // A store that also sets mem_to_reg is still a store.
               if (csr_q)                rfdata_d = csrres_q;
               else if (to_reg_q && !wen_q) rfdata_d = load_data;
               else                      rfdata_d = addr_q;
            end
         end
         ST_RESP: begin
            if (resp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and request registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         csrres_q   <= '0;
         rfdata_q   <= '0;
         mem_op_q   <= '0;
         to_reg_q   <= 1'b0;
         wen_q      <= 1'b0;
         csr_q      <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         csrres_q   <= csrres_d;
         rfdata_q   <= rfdata_d;
         mem_op_q   <= mem_op_d;
         to_reg_q   <= to_reg_d;
         wen_q      <= wen_d;
         csr_q      <= csr_d;
         misalign_q <= misalign_d;
      end
   end

   // Outputs decode the state register and latched request fields only.
   assign req_ready_o   = (state_q == ST_IDLE);
   assign m_busy        = (state_q != ST_IDLE);
   assign resp_valid_o  = (state_q == ST_RESP);
   assign d_rw_valid_o  = (state_q == ST_DREQ);
   assign d_rw_req_o    = d_rw_valid_o & wen_q;
   assign d_rw_wstrb_o  = d_rw_req_o ? st_wstrb : '0;
   assign d_rw_w_data_o = st_wdata;
   assign d_rw_addr_o   = addr_q;
   assign rfdata_o      = rfdata_q;
   assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_ysyx_220053_lsu.sv
// tb_ysyx_220053_lsu: directed and randomized checks of the LSU against a
// byte-level reference model (sizes, lanes, extension and latency).
module tb_ysyx_220053_lsu;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid_i;
   logic         req_ready_o;
   logic [2:0]   mem_op_i;
   logic         mem_to_reg_i, mem_wen_i, csr_to_reg_i;
   logic [63:0]  addr_i, wdata_i, csrres_i;
   logic         resp_valid_o, resp_ready_i;
   logic [63:0]  rfdata_o;
   logic         misalign_o, m_busy;
   logic [63:0]  d_rw_addr_o;
   logic         d_rw_req_o, d_rw_valid_o;
   logic [127:0] d_rw_w_data_o;
   logic [15:0]  d_rw_wstrb_o;
   logic [127:0] d_data_read_i;
   logic         d_rw_ready_i;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ysyx_220053_lsu #(.XLEN(64), .LINE_W(128)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .mem_op_i      (mem_op_i),
      .mem_to_reg_i  (mem_to_reg_i),
      .mem_wen_i     (mem_wen_i),
      .csr_to_reg_i  (csr_to_reg_i),
      .addr_i        (addr_i),
      .wdata_i       (wdata_i),
      .csrres_i      (csrres_i),
      .resp_valid_o  (resp_valid_o),
      .resp_ready_i  (resp_ready_i),
      .rfdata_o      (rfdata_o),
      .misalign_o    (misalign_o),
      .m_busy        (m_busy),
      .d_rw_addr_o   (d_rw_addr_o),
      .d_rw_req_o    (d_rw_req_o),
      .d_rw_valid_o  (d_rw_valid_o),
      .d_rw_w_data_o (d_rw_w_data_o),
      .d_rw_wstrb_o  (d_rw_wstrb_o),
      .d_data_read_i (d_data_read_i),
      .d_rw_ready_i  (d_rw_ready_i)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [127:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Reference load: gather size bytes starting at the lane offset, then extend.
   function automatic logic [63:0] ref_load(input logic [2:0] op, input logic [63:0] addr,
                                            input logic [127:0] line);
      int sz;
      int off;
      logic [63:0] v;
      sz  = 1 << op[1:0];
      off = int'(addr[3:0]);
      v   = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = line[8*(off+i) +: 8];
      if (!op[2] && sz < 8 && v[8*sz-1])
         for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic scramble_req();
      mem_op_i     = 3'($urandom_range(0, 7));
      mem_to_reg_i = 1'($urandom_range(0, 1));
      mem_wen_i    = 1'($urandom_range(0, 1));
      csr_to_reg_i = 1'($urandom_range(0, 1));
      addr_i       = {$urandom, $urandom};
      wdata_i      = {$urandom, $urandom};
      csrres_i     = {$urandom, $urandom};
   endtask

   task automatic run_txn(input logic [2:0] op, input logic to_reg, input logic wen,
                          input logic csr, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [63:0] cr, input logic [127:0] line,
                          input int rdy_dly, input int rsp_dly);
      int sz;
      int off;
      logic mem, mis, st;
      logic [63:0] exp_rf, got_l, exp_l;
      logic [15:0] exp_strb;
      sz  = 1 << op[1:0];
      off = int'(addr[3:0]);
      mem = to_reg | wen;
      st  = wen;
      mis = mem && ((addr % 64'(sz)) != 64'd0);
      exp_strb = '0;
      exp_l    = '0;
      if (st) for (int i = 0; i < sz; i++) exp_strb[off+i] = 1'b1;
      for (int i = 0; i < sz; i++) exp_l[8*i +: 8] = wd[8*i +: 8];
      if (mis)                exp_rf = '0;
      else if (csr)           exp_rf = cr;
      else if (to_reg && !st) exp_rf = ref_load(op, addr, line);
      else                    exp_rf = addr;

      @(negedge clk);
      check_eq("idle_req_ready", req_ready_o, 1'b1);
      req_valid_i   = 1'b1;
      mem_op_i      = op;
      mem_to_reg_i  = to_reg;
      mem_wen_i     = wen;
      csr_to_reg_i  = csr;
      addr_i        = addr;
      wdata_i       = wd;
      csrres_i      = cr;
      d_rw_ready_i  = 1'($urandom_range(0, 1));
      d_data_read_i = rand_line();
      @(posedge clk);
      @(negedge clk);
      req_valid_i  = 1'b0;
      d_rw_ready_i = 1'b0;
      scramble_req();

      if (mem && !mis) begin
         for (int c = 0; c <= rdy_dly; c++) begin
            if (c > 0) @(negedge clk);
            check_eq("dreq_valid", d_rw_valid_o, 1'b1);
            check_eq("dreq_addr", d_rw_addr_o, addr);
            check_eq("dreq_req", d_rw_req_o, st);
            check_eq("dreq_wstrb", d_rw_wstrb_o, exp_strb);
            check_eq("dreq_ready_low", req_ready_o, 1'b0);
            if (st) begin
               got_l = '0;
               for (int i = 0; i < sz; i++) got_l[8*i +: 8] = d_rw_w_data_o[8*(off+i) +: 8];
               check_eq("dreq_wdata_lane", got_l, exp_l);
            end
            d_rw_ready_i  = (c == rdy_dly);
            d_data_read_i = (c == rdy_dly) ? line : rand_line();
            @(posedge clk);
         end
         @(negedge clk);
         d_rw_ready_i  = 1'b0;
         d_data_read_i = rand_line();
      end else begin
         check_eq("no_cache_req", d_rw_valid_o, 1'b0);
      end

      for (int r = 0; r <= rsp_dly; r++) begin
         if (r > 0) @(negedge clk);
         check_eq("resp_valid", resp_valid_o, 1'b1);
         check_eq("resp_rfdata", rfdata_o, exp_rf);
         check_eq("resp_misalign", misalign_o, mis);
         check_eq("resp_busy", m_busy, 1'b1);
         check_eq("resp_no_dreq", d_rw_valid_o, 1'b0);
         resp_ready_i = (r == rsp_dly);
         d_rw_ready_i = 1'($urandom_range(0, 1));
         @(posedge clk);
      end
      @(negedge clk);
      resp_ready_i = 1'b0;
      d_rw_ready_i = 1'b0;
      check_eq("back_idle_valid", resp_valid_o, 1'b0);
      check_eq("back_idle_busy", m_busy, 1'b0);
   endtask

   initial begin
      logic [127:0] line;
      logic [2:0]   op;
      logic [63:0]  addr;
      logic         to_reg, wen, csr;
      int           kind, sz;

      rst = 1'b0;
      req_valid_i = 1'b0; resp_ready_i = 1'b0; d_rw_ready_i = 1'b0;
      scramble_req();
      d_data_read_i = rand_line();
      #12;
      check_eq("rst_req_ready", req_ready_o, 1'b1);
      check_eq("rst_resp_valid", resp_valid_o, 1'b0);
      check_eq("rst_dvalid", d_rw_valid_o, 1'b0);
      check_eq("rst_dreq", d_rw_req_o, 1'b0);
      check_eq("rst_misalign", misalign_o, 1'b0);
      check_eq("rst_busy", m_busy, 1'b0);
      check_eq("rst_wstrb", d_rw_wstrb_o, 16'h0);
      check_eq("rst_rfdata", rfdata_o, 64'h0);
      check_eq("rst_addr", d_rw_addr_o, 64'h0);
      @(negedge clk);
      rst = 1'b1;

      // lb / lbu with byte 3 = 0x80
      line = rand_line();
      line[31:24] = 8'h80;
      run_txn(3'b000, 1'b1, 1'b0, 1'b0, 64'h8000_0003, 64'h0, 64'h0, line, 0, 0);
      check_eq("lb_value", rfdata_o, 64'hFFFF_FFFF_FFFF_FF80);
      run_txn(3'b100, 1'b1, 1'b0, 1'b0, 64'h8000_0003, 64'h0, 64'h0, line, 1, 0);
      check_eq("lbu_value", rfdata_o, 64'h80);
      // sd into the upper half of the line
      run_txn(3'b011, 1'b0, 1'b1, 1'b0, 64'h8000_0008, 64'h1122334455667788, 64'h0,
              rand_line(), 0, 1);
      // misaligned lw
      run_txn(3'b010, 1'b1, 1'b0, 1'b0, 64'h8000_0002, 64'h0, 64'h0, rand_line(), 0, 0);
      // ld with a slow cache and a slow writeback
      run_txn(3'b011, 1'b1, 1'b0, 1'b0, 64'h8000_0010, 64'h0, 64'h0, rand_line(), 5, 3);
      // CSR writeback of a non-memory op
      run_txn(3'b000, 1'b0, 1'b0, 1'b1, 64'h1234, 64'h0, 64'hABCD, rand_line(), 0, 0);
      check_eq("csr_value", rfdata_o, 64'hABCD);
      // load+store flags together behave as a store
      run_txn(3'b010, 1'b1, 1'b1, 1'b0, 64'h8000_0004, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,
              rand_line(), 2, 0);

      // Reset in the middle of DREQ abandons the access.
      @(negedge clk);
      req_valid_i = 1'b1; mem_op_i = 3'b011; mem_to_reg_i = 1'b1; mem_wen_i = 1'b0;
      csr_to_reg_i = 1'b0; addr_i = 64'h8000_0020;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      check_eq("pre_rst_dvalid", d_rw_valid_o, 1'b1);
      #2 rst = 1'b0;
      #1;
      check_eq("mid_rst_dvalid", d_rw_valid_o, 1'b0);
      check_eq("mid_rst_ready", req_ready_o, 1'b1);
      check_eq("mid_rst_busy", m_busy, 1'b0);
      check_eq("mid_rst_addr", d_rw_addr_o, 64'h0);
      @(negedge clk);
      rst = 1'b1;
      run_txn(3'b001, 1'b1, 1'b0, 1'b0, 64'h8000_0006, 64'h0, 64'h0, rand_line(), 1, 1);

      // Randomized traffic.
      for (int n = 0; n < 200; n++) begin
         op   = 3'($urandom_range(0, 6));
         kind = $urandom_range(0, 3);
         to_reg = (kind == 1) || (kind == 3);
         wen    = (kind == 2) || (kind == 3);
         csr    = ($urandom_range(0, 7) == 0);
         addr   = {32'h0, 32'h8000_0000 | ($urandom & 32'hFF)};
         sz     = 1 << op[1:0];
         if ($urandom_range(0, 1) == 1) addr = addr - (addr % 64'(sz));
         run_txn(op, to_reg, wen, csr, addr, {$urandom, $urandom}, {$urandom, $urandom},
                 rand_line(), $urandom_range(0, 4), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
